// File: rtl/tdm_demux_bmsce_pkg.sv
// Shared definitions for the 2:1 TDM bit-link receiver.
package tdm_pkg;

  // Bits per channel per frame; a frame interleaves two channels.
  localparam int CHAN_W    = 8;
  localparam int FRAME_LEN = 2 * CHAN_W;
  localparam int CNT_W     = 5;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(FRAME_LEN - 1);

  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } state_e;

  // Bit positions within uio_out.
  localparam int UIO_VALID_A   = 0;
  localparam int UIO_VALID_B   = 1;
  localparam int UIO_OVR_A     = 2;
  localparam int UIO_OVR_B     = 3;
  localparam int UIO_LOCK      = 4;
  localparam int UIO_FRAME_ERR = 5;

  localparam logic [7:0] UIO_OE_MASK = 8'h3F;

endpackage

// File: rtl/tdm_demux_bmsce_chan_rx.sv
// One receive channel: MSB-first shift register, holding register,
// valid/overrun flags and ack rising-edge detection.
module tdm_chan_rx
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ser_d,
  input  logic              shift_en,
  input  logic              load,
  input  logic              ack,
  output logic [CHAN_W-1:0] hold,
  output logic              valid,
  output logic              ovr,
  output logic              ack_rise
);

  logic [CHAN_W-1:0] sh;
  logic              ack_d;

  assign ack_rise = ack & ~ack_d;

  // Shift, load-on-completion (completion beats a same-cycle ack) and ack clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh    <= '0;
      hold  <= '0;
      valid <= 1'b0;
      ovr   <= 1'b0;
      ack_d <= 1'b0;
    end else begin
      ack_d <= ack;
      if (shift_en) begin
        sh <= {sh[CHAN_W-2:0], ser_d};
      end
      if (load) begin
        if (valid && !ack_rise) begin
          // Previous byte not yet consumed: keep it and flag the loss.
          ovr <= 1'b1;
        end else begin
          hold  <= sh;
          valid <= 1'b1;
          ovr   <= 1'b0;
        end
      end else if (ack_rise && valid) begin
        valid <= 1'b0;
        ovr   <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/tdm_demux_bmsce.sv
// Receiver for the 2:1 interleaved bit link, wrapped in the standard
// user-project pinout. Frame sync tracking lives here; per-channel data
// handling lives in tdm_chan_rx.
module tdm_demux_bmsce
  import tdm_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic ser_d, fsync, bit_en, ack_a, ack_b, rd_sel;
  assign ser_d  = ui_in[0];
  assign fsync  = ui_in[1];
  assign bit_en = ui_in[2];
  assign ack_a  = ui_in[3];
  assign ack_b  = ui_in[4];
  assign rd_sel = ui_in[5];

  logic unused_pins;
  assign unused_pins = &{1'b0, ena, uio_in, ui_in[7:6]};

  state_e           state;
  logic [CNT_W-1:0] bit_cnt;
  logic             cmp_pend;
  logic             frame_err;

  logic              shift_a, shift_b;
  logic [CHAN_W-1:0] hold_a, hold_b;
  logic              valid_a, valid_b, ovr_a, ovr_b;
  logic              rise_a, rise_b;

  // Steer the current bit to channel A (even slot) or B (odd slot).
  always_comb begin
    shift_a = 1'b0;
    shift_b = 1'b0;
    if (bit_en) begin
      if (state == HUNT) begin
        shift_a = fsync;
      end else if (fsync) begin
        shift_a = 1'b1;
      end else if (bit_cnt != '0) begin
        shift_a = ~bit_cnt[0];
        shift_b = bit_cnt[0];
      end
    end
  end

  // Frame sync FSM: hunt for fsync, count slots, detect sync errors.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= HUNT;
      bit_cnt   <= '0;
      cmp_pend  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      cmp_pend <= 1'b0;
      if (rise_a && rise_b) begin
        frame_err <= 1'b0;
      end
      if (bit_en) begin
        case (state)
          HUNT: begin
            if (fsync) begin
              state   <= RECV;
              bit_cnt <= CNT_W'(1);
            end
          end
          RECV: begin
            if (fsync) begin
              // A sync bit always restarts the frame; mid-frame it is a resync.
              bit_cnt <= CNT_W'(1);
              if (bit_cnt != '0) begin
                frame_err <= 1'b1;
              end
            end else if (bit_cnt == '0) begin
              // Expected the next frame's sync after the wrap.
              state     <= HUNT;
              frame_err <= 1'b1;
            end else if (bit_cnt == LAST_SLOT) begin
              bit_cnt  <= '0;
              cmp_pend <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  tdm_chan_rx u_chan_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .ser_d    (ser_d),
    .shift_en (shift_a),
    .load     (cmp_pend),
    .ack      (ack_a),
    .hold     (hold_a),
    .valid    (valid_a),
    .ovr      (ovr_a),
    .ack_rise (rise_a)
  );

  tdm_chan_rx u_chan_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .ser_d    (ser_d),
    .shift_en (shift_b),
    .load     (cmp_pend),
    .ack      (ack_b),
    .hold     (hold_b),
    .valid    (valid_b),
    .ovr      (ovr_b),
    .ack_rise (rise_b)
  );

  assign uo_out = rd_sel ? hold_b : hold_a;
  assign uio_oe = UIO_OE_MASK;

  // Pack status flags onto the bidirectional pins.
  always_comb begin
    uio_out                = 8'h00;
    uio_out[UIO_VALID_A]   = valid_a;
    uio_out[UIO_VALID_B]   = valid_b;
    uio_out[UIO_OVR_A]     = ovr_a;
    uio_out[UIO_OVR_B]     = ovr_b;
    uio_out[UIO_LOCK]      = (state == RECV);
    uio_out[UIO_FRAME_ERR] = frame_err;
  end

endmodule

// File: tb/tb_tdm_demux_bmsce.sv
// Directed bench for the TDM bit-link receiver.
module tb_tdm_demux_bmsce;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] uo_out, uio_out, uio_oe;

  logic ser_d = 0, fsync = 0, bit_en = 0, ack_a = 0, ack_b = 0, rd_sel = 0;
  logic [7:0] ui_in;
  assign ui_in = {2'b00, rd_sel, ack_b, ack_a, bit_en, fsync, ser_d};

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tdm_demux_bmsce dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (1'b1),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (8'h00),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bit event followed by one idle (bit_en = 0) cycle.
  task automatic send_bit(input logic d, input logic fs);
    ser_d  = d;
    fsync  = fs;
    bit_en = 1'b1;
    tick();
    bit_en = 1'b0;
    fsync  = 1'b0;
    tick();
  endtask

  // Full frame with idle gaps; optional ack_a rise on the completion edge
  // and optional check that valid_a is still low right after the last bit.
  task automatic send_frame(input logic [7:0] a, input logic [7:0] b,
                            input logic fs, input logic ack_done,
                            input logic chk_lat);
    for (int i = 0; i < 16; i++) begin
      int idx;
      idx    = 7 - i / 2;
      ser_d  = (i % 2 == 0) ? a[idx] : b[idx];
      fsync  = fs && (i == 0);
      bit_en = 1'b1;
      tick();
      bit_en = 1'b0;
      fsync  = 1'b0;
      if (i == 15) begin
        if (chk_lat) chk("latency_valid_a_low", {7'b0, uio_out[0]}, 8'h00);
        ack_a = ack_done;
      end
      tick();
    end
    ack_a = 1'b0;
  endtask

  task automatic pulse_ack(input logic a, input logic b);
    ack_a = a;
    ack_b = b;
    tick();
    ack_a = 1'b0;
    ack_b = 1'b0;
    tick();
  endtask

  initial begin
    // Reset with busy inputs
    rst_n = 1'b0;
    ser_d = 1; fsync = 1; bit_en = 1; ack_a = 1; ack_b = 1; rd_sel = 1;
    tick();
    tick();
    chk("rst_uo", uo_out, 8'h00);
    chk("rst_uio", uio_out, 8'h00);
    chk("rst_oe", uio_oe, 8'h3F);
    ser_d = 0; fsync = 0; bit_en = 0; ack_a = 0; ack_b = 0; rd_sel = 0;
    rst_n = 1'b1;
    tick();
    chk("post_rst_uio", uio_out, 8'h00);

    // Nominal frame A=A5 B=3C
    send_frame(8'hA5, 8'h3C, 1'b1, 1'b0, 1'b1);
    chk("nom_uio", uio_out, 8'h13);
    chk("nom_hold_a", uo_out, 8'hA5);
    rd_sel = 1'b1; #1;
    chk("nom_hold_b", uo_out, 8'h3C);
    rd_sel = 1'b0; #1;

    // Overrun on A while B is acked
    pulse_ack(1'b0, 1'b1);
    chk("ackb_uio", uio_out, 8'h11);
    send_frame(8'h11, 8'h22, 1'b1, 1'b0, 1'b0);
    chk("ovr_uio", uio_out, 8'h17);
    chk("ovr_hold_a", uo_out, 8'hA5);
    rd_sel = 1'b1; #1;
    chk("ovr_hold_b", uo_out, 8'h22);
    rd_sel = 1'b0; #1;
    pulse_ack(1'b1, 1'b0);
    chk("acka_uio", uio_out, 8'h12);

    // Refill A; B overruns and keeps 22
    send_frame(8'hC3, 8'h44, 1'b1, 1'b0, 1'b0);
    chk("refill_uio", uio_out, 8'h1B);
    chk("refill_hold_a", uo_out, 8'hC3);

    // Ack rise on completion edge: new data wins, no overrun
    send_frame(8'h5A, 8'h66, 1'b1, 1'b1, 1'b0);
    chk("simul_uio", uio_out, 8'h1B);
    chk("simul_hold_a", uo_out, 8'h5A);
    rd_sel = 1'b1; #1;
    chk("simul_hold_b", uo_out, 8'h22);
    rd_sel = 1'b0; #1;
    pulse_ack(1'b0, 1'b1);
    pulse_ack(1'b1, 1'b0);
    chk("cleared_uio", uio_out, 8'h10);

    // Resync: fsync arrives at slot 6
    for (int i = 0; i < 6; i++) send_bit(1'b1, i == 0);
    chk("pre_resync_uio", uio_out, 8'h10);
    send_frame(8'h96, 8'h69, 1'b1, 1'b0, 1'b0);
    chk("resync_uio", uio_out, 8'h33);
    chk("resync_hold_a", uo_out, 8'h96);
    rd_sel = 1'b1; #1;
    chk("resync_hold_b", uo_out, 8'h69);
    rd_sel = 1'b0; #1;
    pulse_ack(1'b1, 1'b1);
    chk("err_clear_uio", uio_out, 8'h10);

    // Missing fsync after wrap drops lock
    send_bit(1'b1, 1'b0);
    chk("nosync_uio", uio_out, 8'h20);
    send_frame(8'hF0, 8'h0F, 1'b0, 1'b0, 1'b0);
    chk("hunt_novalid_uio", uio_out, 8'h20);
    chk("hunt_hold_a", uo_out, 8'h96);

    // Mid-frame reset at bit 9
    for (int i = 0; i < 9; i++) send_bit(i[0], i == 0);
    chk("midframe_lock", uio_out, 8'h30);
    rst_n = 1'b0; ser_d = 1'b1; bit_en = 1'b1;
    tick();
    rst_n = 1'b1; bit_en = 1'b0; ser_d = 1'b0;
    chk("midrst_uio", uio_out, 8'h00);
    chk("midrst_uo", uo_out, 8'h00);
    send_frame(8'hFF, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("fresh_uio", uio_out, 8'h13);
    chk("fresh_hold_a", uo_out, 8'hFF);
    rd_sel = 1'b1; #1;
    chk("fresh_hold_b", uo_out, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
